// File: rtl/ip_mdd_apb_tmo_if.sv
// rtl/ip_mdd_apb_tmo_if.sv - 32-bit APB4 bus interface shared by the timeout bridge ports
interface apb4_if;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/ip_mdd_apb_tmo.sv
// rtl/ip_mdd_apb_tmo.sv - APB4 timeout bridge in front of the MDD wrapper; MDD_APB_PSLVERR_EN enables pslverr on forced completions
module ip_mdd_apb_tmo #(
    parameter int unsigned TMO_CYCLES = 256,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_C0DE
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    apb4_if.slave                mst,
    apb4_if.master               slv,
    output logic                 tmo_irq_o,
    output logic [CNT_WIDTH-1:0] tmo_cnt_o,
    output logic                 busy_o
);

`ifdef MDD_APB_PSLVERR_EN
    localparam logic PSLVERR_EN = 1'b1;
`else
    localparam logic PSLVERR_EN = 1'b0;
`endif

    localparam logic [15:0] TMO_LIM = 16'(TMO_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic [31:0] hold_paddr;
    logic [2:0]  hold_pprot;
    logic        hold_pwrite;
    logic [31:0] hold_pwdata;
    logic [3:0]  hold_pstrb;

    logic mst_setup;
    logic mst_access;
    logic capture;
    logic tmo_evt;

    assign mst_setup  = mst.psel & ~mst.penable;
    assign mst_access = mst.psel & mst.penable;

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        tmo_evt     = 1'b0;
        slv.paddr   = mst.paddr;
        slv.pprot   = mst.pprot;
        slv.psel    = mst.psel;
        slv.penable = mst.penable;
        slv.pwrite  = mst.pwrite;
        slv.pwdata  = mst.pwdata;
        slv.pstrb   = mst.pstrb;
        mst.pready  = 1'b0;
        mst.prdata  = '0;
        mst.pslverr = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mst_setup) begin
                    capture   = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (slv.pready) begin
                    mst.pready  = 1'b1;
                    mst.prdata  = slv.prdata;
                    mst.pslverr = PSLVERR_EN & slv.pslverr;
                    state_nxt   = ST_IDLE;
                end else if (wait_cnt >= TMO_LIM) begin
                    mst.pready  = 1'b1;
                    mst.prdata  = ERR_RDATA;
                    mst.pslverr = PSLVERR_EN;
                    tmo_evt     = 1'b1;
                    state_nxt   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A setup that coincides with the hung IP finally answering is forwarded as a fresh transfer
                if (slv.pready && mst_setup) begin
                    capture   = 1'b1;
                    state_nxt = ST_ACCESS;
                end else begin
                    slv.paddr   = hold_paddr;
                    slv.pprot   = hold_pprot;
                    slv.psel    = 1'b1;
                    slv.penable = 1'b1;
                    slv.pwrite  = hold_pwrite;
                    slv.pwdata  = hold_pwdata;
                    slv.pstrb   = hold_pstrb;
                    if (slv.pready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                if (mst_access) begin
                    mst.pready  = 1'b1;
                    mst.prdata  = ERR_RDATA;
                    mst.pslverr = PSLVERR_EN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter reads 1 in the first penable cycle, so the limit hits in access cycle TMO_CYCLES
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (capture) begin
            wait_cnt <= 16'd1;
        end else if (state == ST_ACCESS && !slv.pready && wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_paddr  <= '0;
            hold_pprot  <= '0;
            hold_pwrite <= 1'b0;
            hold_pwdata <= '0;
            hold_pstrb  <= '0;
        end else if (capture) begin
            hold_paddr  <= mst.paddr;
            hold_pprot  <= mst.pprot;
            hold_pwrite <= mst.pwrite;
            hold_pwdata <= mst.pwdata;
            hold_pstrb  <= mst.pstrb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_o <= '0;
        end else if (tmo_evt && tmo_cnt_o != {CNT_WIDTH{1'b1}}) begin
            tmo_cnt_o <= tmo_cnt_o + 1'b1;
        end
    end

    assign tmo_irq_o = tmo_evt;
    assign busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_ip_mdd_apb_tmo.sv
// tb/tb_ip_mdd_apb_tmo.sv - self-checking bench for ip_mdd_apb_tmo (TMO_CYCLES=16, CNT_WIDTH=2)
module tb_ip_mdd_apb_tmo;
    localparam int TMO = 16;
    localparam int CW  = 2;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_C0DE;
`ifdef MDD_APB_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb4_if mst_bus ();
    apb4_if slv_bus ();
    logic          tmo_irq;
    logic [CW-1:0] tmo_cnt;
    logic          busy;

    ip_mdd_apb_tmo #(
        .TMO_CYCLES (TMO),
        .CNT_WIDTH  (CW),
        .ERR_RDATA  (ERR_WORD)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .mst       (mst_bus),
        .slv       (slv_bus),
        .tmo_irq_o (tmo_irq),
        .tmo_cnt_o (tmo_cnt),
        .busy_o    (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        mst_bus.paddr   = '0;
        mst_bus.pprot   = '0;
        mst_bus.psel    = 1'b0;
        mst_bus.penable = 1'b0;
        mst_bus.pwrite  = 1'b0;
        mst_bus.pwdata  = '0;
        mst_bus.pstrb   = '0;
        slv_bus.pready  = 1'b0;
        slv_bus.prdata  = '0;
        slv_bus.pslverr = 1'b0;
    endtask

    // One upstream transfer; slave answers in access cycle rdy (0 = never). Ends at posedge+1 with bus idle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input int rdy,
                        input logic [31:0] srdata, input logic serr, output int done_cyc,
                        output logic [31:0] rdata, output logic err, output int irqs, output logic [31:0] slv_addr);
        done_cyc = 0;
        irqs     = 0;
        rdata    = '0;
        err      = 1'b0;
        slv_addr = '0;
        @(posedge clk); #1;
        mst_bus.paddr   = addr;
        mst_bus.pprot   = 3'b010;
        mst_bus.pwrite  = wr;
        mst_bus.pwdata  = wdata;
        mst_bus.pstrb   = 4'hF;
        mst_bus.psel    = 1'b1;
        mst_bus.penable = 1'b0;
        slv_bus.pready  = 1'b0;
        @(posedge clk); #1;
        mst_bus.penable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            slv_bus.pready  = (c == rdy);
            slv_bus.prdata  = (c == rdy) ? srdata : 32'h0;
            slv_bus.pslverr = (c == rdy) & serr;
            @(negedge clk);
            if (tmo_irq) irqs++;
            slv_addr = slv_bus.paddr;
            if (mst_bus.pready) begin
                done_cyc = c;
                rdata    = mst_bus.prdata;
                err      = mst_bus.pslverr;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic release_drain(input string tag);
        @(negedge clk);
        chk({tag, " busy in drain"}, busy, 1);
        @(posedge clk); #1;
        slv_bus.pready = 1'b1;
        @(posedge clk); #1;
        slv_bus.pready = 1'b0;
        @(negedge clk);
        chk({tag, " busy after release"}, busy, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          rdy;
        logic [31:0] srdata;
        logic        serr;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_irq;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          irqs;
        logic [31:0] rd;
        logic        er;
        logic [31:0] sa;

        vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,         3,  32'h1234_5678, 1'b0, 3,  32'h1234_5678, 1'b0, 0, 0};
        vecs[1] = '{32'h0000_0104, 1'b1, 32'h0BAD_F00D, 1,  32'h0,         1'b0, 1,  32'h0,         1'b0, 0, 0};
        vecs[2] = '{32'h0000_0108, 1'b0, 32'h0,         16, 32'hA5A5_0001, 1'b0, 16, 32'hA5A5_0001, 1'b0, 0, 0};
        vecs[3] = '{32'h0000_010C, 1'b0, 32'h0,         2,  32'h5555_AAAA, 1'b1, 2,  32'h5555_AAAA, 1'b1, 0, 0};
        vecs[4] = '{32'h0000_0110, 1'b0, 32'h0,         17, 32'h7777_7777, 1'b0, 16, ERR_WORD,      1'b1, 1, 1};

        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pready", mst_bus.pready, 0);
        chk("reset prdata", mst_bus.prdata, 0);
        chk("reset pslverr", mst_bus.pslverr, 0);
        chk("reset irq", tmo_irq, 0);
        chk("reset busy", busy, 0);
        chk("reset cnt", tmo_cnt, 0);
        chk("reset slv psel", slv_bus.psel, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdy, vecs[i].srdata, vecs[i].serr, cyc, rd, er, irqs, sa);
            chk($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d pslverr", i), er, ERR_EN & vecs[i].exp_err);
            chk($sformatf("vec%0d irq pulses", i), irqs, vecs[i].exp_irq);
            chk($sformatf("vec%0d slv paddr", i), sa, vecs[i].addr);
            if (vecs[i].exp_irq != 0) release_drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tmo_cnt", i), tmo_cnt, vecs[i].exp_cnt);
        end

        // Timeout then three fast-failed writes while the slave stays hung
        xfer(32'h0000_0200, 1'b0, 32'h0, 0, 32'h0, 1'b0, cyc, rd, er, irqs, sa);
        chk("tmo2 cycles", cyc, TMO);
        chk("tmo2 irq pulses", irqs, 1);
        chk("tmo2 cnt", tmo_cnt, 2);
        for (int k = 0; k < 3; k++) begin
            xfer(32'h0000_0500 + k, 1'b1, 32'h1111_0000 + k, 0, 32'h0, 1'b0, cyc, rd, er, irqs, sa);
            chk($sformatf("ff%0d cycles", k), cyc, 1);
            chk($sformatf("ff%0d prdata", k), rd, ERR_WORD);
            chk($sformatf("ff%0d pslverr", k), er, ERR_EN);
            chk($sformatf("ff%0d irq pulses", k), irqs, 0);
            chk($sformatf("ff%0d slv held paddr", k), sa, 32'h0000_0200);
        end
        chk("ff cnt unchanged", tmo_cnt, 2);
        release_drain("ff");

        // Saturation: timeouts 3, 4, 5
        for (int k = 3; k <= 5; k++) begin
            xfer(32'h0000_0600 + k, 1'b0, 32'h0, 20, 32'h0, 1'b0, cyc, rd, er, irqs, sa);
            chk($sformatf("sat%0d cycles", k), cyc, TMO);
            chk($sformatf("sat%0d prdata", k), rd, ERR_WORD);
            release_drain($sformatf("sat%0d", k));
            chk($sformatf("sat%0d cnt", k), tmo_cnt, 3);
        end

        // DRAIN exit coinciding with a new setup
        xfer(32'h0000_0700, 1'b0, 32'h0, 0, 32'h0, 1'b0, cyc, rd, er, irqs, sa);
        chk("dx timeout cycles", cyc, TMO);
        mst_bus.paddr  = 32'h0000_0300;
        mst_bus.pwrite = 1'b0;
        mst_bus.psel   = 1'b1;
        slv_bus.pready = 1'b1;
        @(negedge clk);
        chk("dx slv paddr fwd", slv_bus.paddr, 32'h0000_0300);
        chk("dx slv penable", slv_bus.penable, 0);
        chk("dx slv psel", slv_bus.psel, 1);
        @(posedge clk); #1;
        mst_bus.penable = 1'b1;
        slv_bus.prdata  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("dx pready", mst_bus.pready, 1);
        chk("dx prdata", mst_bus.prdata, 32'hCAFE_F00D);
        chk("dx irq", tmo_irq, 0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("dx busy after", busy, 0);

        // Reset in ACCESS at wait count 10
        @(posedge clk); #1;
        mst_bus.paddr = 32'h0000_0400;
        mst_bus.psel  = 1'b1;
        @(posedge clk); #1;
        mst_bus.penable = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("rst busy before", busy, 1);
        #1;
        rst_n = 1'b0;
        idle_bus();
        #1;
        chk("rst pready", mst_bus.pready, 0);
        chk("rst prdata", mst_bus.prdata, 0);
        chk("rst pslverr", mst_bus.pslverr, 0);
        chk("rst irq", tmo_irq, 0);
        chk("rst busy", busy, 0);
        chk("rst cnt", tmo_cnt, 0);
        chk("rst slv psel", slv_bus.psel, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(32'h0000_0404, 1'b0, 32'h0, 16, 32'h0F0F_1234, 1'b0, cyc, rd, er, irqs, sa);
        chk("post rst cycles", cyc, 16);
        chk("post rst prdata", rd, 32'h0F0F_1234);
        chk("post rst irq", irqs, 0);
        chk("post rst cnt", tmo_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
